// File: rtl/regfile_scoreboard_if.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_if
// Bundles the read, writeback and issue signals of the register file so the
// issue/execute logic and the register file share one port declaration.
// The issue/writeback side uses the master modport; the register file uses slave.
// ---------------------------------------------------------------------------
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              sel_in;
    logic [ADDR_W-1:0] rsa_in;
    logic [ADDR_W-1:0] rsb_in;
    logic [DATA_W-1:0] rsa_val_out;
    logic [DATA_W-1:0] rsb_val_out;
    logic              rsa_busy_out;
    logic              rsb_busy_out;
    logic [ADDR_W-1:0] rd_in;
    logic [DATA_W-1:0] rd_val_in;
    logic              wb_in;
    logic [1:0]        wb_mode_in;
    logic              issue_in;
    logic [ADDR_W-1:0] issue_rd_in;

    modport master (
        output sel_in, rsa_in, rsb_in, rd_in, rd_val_in, wb_in, wb_mode_in,
               issue_in, issue_rd_in,
        input  rsa_val_out, rsb_val_out, rsa_busy_out, rsb_busy_out
    );

    modport slave (
        input  sel_in, rsa_in, rsb_in, rd_in, rd_val_in, wb_in, wb_mode_in,
               issue_in, issue_rd_in,
        output rsa_val_out, rsb_val_out, rsa_busy_out, rsb_busy_out
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Parametrised register file with two registered read ports, one writeback
// port (full word / low half / upper half) and a per-register busy
// scoreboard used by issue logic to detect read-after-write hazards.
//
// Compile-time option:
//   REGFILE_BYPASS_EN - when defined, a read at the same edge as a write to
//                       the same register returns the merged post-write
//                       value. When undefined, reads return the pre-write
//                       value and the forwarding muxes are absent.
// The scoreboard behaves identically in both builds: busy outputs always
// reflect the same-edge set/clear.
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    regfile_scoreboard_if.slave  bus
);

    localparam int HALF_W = DATA_W / 2;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        WB_FULL = 2'b00,
        WB_LOW  = 2'b01,
        WB_HIGH = 2'b10,
        WB_NONE = 2'b11
    } wb_mode_e;

    // Architectural state
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;

    // Next-state / datapath signals
    logic [DEPTH-1:0]  busy_d;
    logic              wr_en;
    logic [DATA_W-1:0] wr_cur;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rsa_d;
    logic [DATA_W-1:0] rsb_d;
    logic              active;
    logic              rd_is_zero;

    assign active     = !bus.sel_in;
    assign rd_is_zero = (ZERO_REG != 0) && (bus.rd_in == '0);

    // Writeback merge: build the full post-write word for the target register
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        wr_en   = active && bus.wb_in && !rd_is_zero;
        wr_cur  = regs[bus.rd_in];
        wr_data = bus.rd_val_in;
        case (wb_mode_e'(bus.wb_mode_in))
            WB_FULL: wr_data = bus.rd_val_in;
            WB_LOW:  wr_data = {wr_cur[DATA_W-1:HALF_W], bus.rd_val_in[HALF_W-1:0]};
            WB_HIGH: wr_data = {bus.rd_val_in[HALF_W-1:0], wr_cur[HALF_W-1:0]};
            WB_NONE: wr_en   = 1'b0;
        endcase
    end

    // Scoreboard next state: writeback clears, issue sets, set wins on a tie
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see
        // earlier ones; the set below deliberately overrides the clear above.
        busy_d = busy_q;
        if (active) begin
            if (bus.wb_in) begin
                busy_d[bus.rd_in] = 1'b0;
            end
            if (bus.issue_in) begin
                busy_d[bus.issue_rd_in] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Read data selection, with optional forwarding of the same-edge write
    always_comb begin
        rsa_d = regs[bus.rsa_in];
        rsb_d = regs[bus.rsb_in];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (bus.rd_in == bus.rsa_in)) begin
            rsa_d = wr_data;
        end
        if (wr_en && (bus.rd_in == bus.rsb_in)) begin
            rsb_d = wr_data;
        end
`else
        // Pre-write value: the write becomes visible one cycle later.
`endif
    end

    // Register array update; reset clears every entry
    always_ff @(posedge clk_in) begin
        // NOTE: the array is reset explicitly because software relies on all
        // registers reading 0 after reset; this forces flops rather than RAM.
        if (reset_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.rd_in] <= wr_data;
        end
    end

    // Scoreboard state register
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Registered read ports; hold while the chip is deselected
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            bus.rsa_val_out  <= '0;
            bus.rsb_val_out  <= '0;
            bus.rsa_busy_out <= 1'b0;
            bus.rsb_busy_out <= 1'b0;
        end else if (active) begin
            bus.rsa_val_out  <= rsa_d;
            bus.rsb_val_out  <= rsb_d;
            bus.rsa_busy_out <= busy_d[bus.rsa_in];
            bus.rsb_busy_out <= busy_d[bus.rsb_in];
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
// Directed scenarios with fixed expected constants, followed by a randomized
// run compared against an array-based reference model of the register file.
// Compile with the same REGFILE_BYPASS_EN setting as the design.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays updated by the architectural rules
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic [31:0] exp_va, exp_vb;
    logic        exp_ba, exp_bb;

    task automatic model_edge();
        logic [31:0] old_a, old_b;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
            exp_va = 32'h0; exp_vb = 32'h0; exp_ba = 1'b0; exp_bb = 1'b0;
        end else if (!bus.sel_in) begin
            old_a = m_regs[bus.rsa_in];
            old_b = m_regs[bus.rsb_in];
            if (bus.wb_in && bus.rd_in != 5'd0) begin
                case (bus.wb_mode_in)
                    2'd0: m_regs[bus.rd_in] = bus.rd_val_in;
                    2'd1: m_regs[bus.rd_in][15:0]  = bus.rd_val_in[15:0];
                    2'd2: m_regs[bus.rd_in][31:16] = bus.rd_val_in[15:0];
                    default: ;
                endcase
            end
            if (bus.wb_in) m_busy[bus.rd_in] = 1'b0;
            if (bus.issue_in && bus.issue_rd_in != 5'd0) m_busy[bus.issue_rd_in] = 1'b1;
            exp_va = BYPASS ? m_regs[bus.rsa_in] : old_a;
            exp_vb = BYPASS ? m_regs[bus.rsb_in] : old_b;
            exp_ba = m_busy[bus.rsa_in];
            exp_bb = m_busy[bus.rsb_in];
        end
    endtask

    // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge
    task automatic cyc(input logic r, input logic sel, input logic wb,
                       input logic [1:0] mode, input logic [4:0] rd,
                       input logic [31:0] val, input logic iss,
                       input logic [4:0] ird, input logic [4:0] ra,
                       input logic [4:0] rb);
        rst = r;
        bus.sel_in = sel; bus.wb_in = wb; bus.wb_mode_in = mode;
        bus.rd_in = rd; bus.rd_val_in = val; bus.issue_in = iss;
        bus.issue_rd_in = ird; bus.rsa_in = ra; bus.rsb_in = rb;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 2'd0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        n_cmp++; if (bus.rsa_val_out !== 32'h0) begin n_fail++; $display("FAIL reset rsa_val: got %h want %h", bus.rsa_val_out, 32'h0); end
        n_cmp++; if (bus.rsb_val_out !== 32'h0) begin n_fail++; $display("FAIL reset rsb_val: got %h want %h", bus.rsb_val_out, 32'h0); end
        n_cmp++; if (bus.rsa_busy_out !== 1'b0) begin n_fail++; $display("FAIL reset rsa_busy: got %b want 0", bus.rsa_busy_out); end
        // Write r5, confirm it landed, then reset and confirm it is gone
        cyc(0, 0, 1, 2'd0, 5'd5, 32'hDEADBEEF, 1, 5'd5, 5'd5, 5'd5);
        cyc(0, 0, 0, 2'd0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd5);
        n_cmp++; if (bus.rsa_val_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reset_pre r5: got %h want %h", bus.rsa_val_out, 32'hDEADBEEF); end
        cyc(1, 0, 1, 2'd0, 5'd5, 32'h77777777, 1, 5'd5, 5'd5, 5'd5);
        n_cmp++; if (bus.rsa_val_out !== 32'h0) begin n_fail++; $display("FAIL reset_mid rsa_val: got %h want %h", bus.rsa_val_out, 32'h0); end
        cyc(0, 0, 0, 2'd0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd5);
        n_cmp++; if (bus.rsa_val_out !== 32'h0) begin n_fail++; $display("FAIL reset_post r5: got %h want %h", bus.rsa_val_out, 32'h0); end
        n_cmp++; if (bus.rsa_busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_post busy: got %b want 0", bus.rsa_busy_out); end
    endtask

    task automatic test_half_writes();
        cyc(0, 0, 1, 2'd0, 5'd3, 32'h12345678, 0, 5'd0, 5'd3, 5'd3);
        cyc(0, 0, 0, 2'd0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd3);
        n_cmp++; if (bus.rsa_val_out !== 32'h12345678) begin n_fail++; $display("FAIL half_full r3: got %h want %h", bus.rsa_val_out, 32'h12345678); end
        cyc(0, 0, 1, 2'd2, 5'd3, 32'h0000ABCD, 0, 5'd0, 5'd3, 5'd3);
        cyc(0, 0, 0, 2'd0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd3);
        n_cmp++; if (bus.rsa_val_out !== 32'hABCD5678) begin n_fail++; $display("FAIL half_upper r3: got %h want %h", bus.rsa_val_out, 32'hABCD5678); end
        cyc(0, 0, 1, 2'd1, 5'd3, 32'h00001111, 0, 5'd0, 5'd3, 5'd3);
        cyc(0, 0, 0, 2'd0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd3);
        n_cmp++; if (bus.rsb_val_out !== 32'hABCD1111) begin n_fail++; $display("FAIL half_low r3: got %h want %h", bus.rsb_val_out, 32'hABCD1111); end
    endtask

    task automatic test_zero_reserved();
        cyc(0, 0, 1, 2'd0, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0, 5'd0);
        cyc(0, 0, 0, 2'd0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        n_cmp++; if (bus.rsa_val_out !== 32'h0) begin n_fail++; $display("FAIL zero_reg val: got %h want %h", bus.rsa_val_out, 32'h0); end
        n_cmp++; if (bus.rsa_busy_out !== 1'b0) begin n_fail++; $display("FAIL zero_reg busy: got %b want 0", bus.rsa_busy_out); end
        cyc(0, 0, 1, 2'd0, 5'd7, 32'h0BADC0DE, 1, 5'd7, 5'd7, 5'd7);
        n_cmp++; if (bus.rsa_busy_out !== 1'b1) begin n_fail++; $display("FAIL r7 issued busy: got %b want 1", bus.rsa_busy_out); end
        cyc(0, 0, 1, 2'd3, 5'd7, 32'hFFFFFFFF, 0, 5'd0, 5'd7, 5'd7);
        n_cmp++; if (bus.rsa_busy_out !== 1'b0) begin n_fail++; $display("FAIL mode11 clears busy: got %b want 0", bus.rsa_busy_out); end
        cyc(0, 0, 0, 2'd0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd7);
        n_cmp++; if (bus.rsa_val_out !== 32'h0BADC0DE) begin n_fail++; $display("FAIL mode11 r7: got %h want %h", bus.rsa_val_out, 32'h0BADC0DE); end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        cyc(0, 0, 1, 2'd0, 5'd9, 32'h11112222, 0, 5'd0, 5'd0, 5'd0);
        cyc(0, 0, 1, 2'd0, 5'd9, 32'hCAFEF00D, 0, 5'd0, 5'd9, 5'd9);
        want = BYPASS ? 32'hCAFEF00D : 32'h11112222;
        n_cmp++; if (bus.rsa_val_out !== want) begin n_fail++; $display("FAIL bypass rsa: got %h want %h", bus.rsa_val_out, want); end
        n_cmp++; if (bus.rsb_val_out !== want) begin n_fail++; $display("FAIL bypass rsb: got %h want %h", bus.rsb_val_out, want); end
        cyc(0, 0, 0, 2'd0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd9);
        n_cmp++; if (bus.rsa_val_out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL bypass later: got %h want %h", bus.rsa_val_out, 32'hCAFEF00D); end
        // Write and issue to r9 while reading it: busy must read 1
        cyc(0, 0, 1, 2'd1, 5'd9, 32'h00003333, 1, 5'd9, 5'd9, 5'd9);
        want = BYPASS ? 32'hCAFE3333 : 32'hCAFEF00D;
        n_cmp++; if (bus.rsa_val_out !== want) begin n_fail++; $display("FAIL wb_issue val: got %h want %h", bus.rsa_val_out, want); end
        n_cmp++; if (bus.rsb_busy_out !== 1'b1) begin n_fail++; $display("FAIL wb_issue busy: got %b want 1", bus.rsb_busy_out); end
        cyc(0, 0, 1, 2'd3, 5'd9, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_scoreboard();
        cyc(0, 0, 0, 2'd0, 5'd0, 32'h0, 1, 5'd12, 5'd12, 5'd1);
        n_cmp++; if (bus.rsa_busy_out !== 1'b1) begin n_fail++; $display("FAIL sb issue: got %b want 1", bus.rsa_busy_out); end
        cyc(0, 0, 1, 2'd0, 5'd12, 32'h5, 0, 5'd0, 5'd12, 5'd12);
        n_cmp++; if (bus.rsa_busy_out !== 1'b0) begin n_fail++; $display("FAIL sb wb clear: got %b want 0", bus.rsa_busy_out); end
        cyc(0, 0, 1, 2'd0, 5'd12, 32'h6, 1, 5'd12, 5'd12, 5'd12);
        n_cmp++; if (bus.rsa_busy_out !== 1'b1) begin n_fail++; $display("FAIL sb tie set wins: got %b want 1", bus.rsa_busy_out); end
        cyc(0, 0, 0, 2'd0, 5'd0, 32'h0, 0, 5'd0, 5'd13, 5'd12);
        n_cmp++; if (bus.rsb_busy_out !== 1'b1) begin n_fail++; $display("FAIL sb hold: got %b want 1", bus.rsb_busy_out); end
        n_cmp++; if (bus.rsa_busy_out !== 1'b0) begin n_fail++; $display("FAIL sb other reg: got %b want 0", bus.rsa_busy_out); end
        cyc(0, 0, 1, 2'd3, 5'd12, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_chip_select();
        cyc(0, 0, 1, 2'd0, 5'd4, 32'h000000AA, 0, 5'd0, 5'd0, 5'd0);
        cyc(0, 0, 0, 2'd0, 5'd0, 32'h0, 0, 5'd0, 5'd4, 5'd3);
        cyc(0, 1, 1, 2'd0, 5'd4, 32'h00000055, 1, 5'd4, 5'd9, 5'd4);
        n_cmp++; if (bus.rsa_val_out !== 32'h000000AA) begin n_fail++; $display("FAIL cs hold rsa: got %h want %h", bus.rsa_val_out, 32'h000000AA); end
        n_cmp++; if (bus.rsb_val_out !== 32'hABCD1111) begin n_fail++; $display("FAIL cs hold rsb: got %h want %h", bus.rsb_val_out, 32'hABCD1111); end
        cyc(0, 0, 0, 2'd0, 5'd0, 32'h0, 0, 5'd0, 5'd4, 5'd4);
        n_cmp++; if (bus.rsa_val_out !== 32'h000000AA) begin n_fail++; $display("FAIL cs no write r4: got %h want %h", bus.rsa_val_out, 32'h000000AA); end
        n_cmp++; if (bus.rsa_busy_out !== 1'b0) begin n_fail++; $display("FAIL cs no issue r4: got %b want 0", bus.rsa_busy_out); end
    endtask

    task automatic test_random();
        logic        r, s, w, iss;
        logic [1:0]  mode;
        logic [4:0]  rd, ird, ra, rb;
        for (int i = 0; i < 600; i++) begin
            r    = ($urandom_range(0, 49) == 0);
            s    = ($urandom_range(0, 7) == 0);
            w    = $urandom_range(0, 1);
            iss  = $urandom_range(0, 1);
            mode = 2'($urandom_range(0, 3));
            rd   = 5'($urandom_range(0, 7));
            ird  = 5'($urandom_range(0, 7));
            ra   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rb   = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 7));
            cyc(r, s, w, mode, rd, $urandom, iss, ird, ra, rb);
            n_cmp++; if (bus.rsa_val_out !== exp_va) begin n_fail++; $display("FAIL random[%0d] rsa_val: got %h want %h", i, bus.rsa_val_out, exp_va); end
            n_cmp++; if (bus.rsb_val_out !== exp_vb) begin n_fail++; $display("FAIL random[%0d] rsb_val: got %h want %h", i, bus.rsb_val_out, exp_vb); end
            n_cmp++; if (bus.rsa_busy_out !== exp_ba) begin n_fail++; $display("FAIL random[%0d] rsa_busy: got %b want %b", i, bus.rsa_busy_out, exp_ba); end
            n_cmp++; if (bus.rsb_busy_out !== exp_bb) begin n_fail++; $display("FAIL random[%0d] rsb_busy: got %b want %b", i, bus.rsb_busy_out, exp_bb); end
        end
    endtask

    initial begin
        bus.sel_in = 1'b0; bus.wb_in = 1'b0; bus.wb_mode_in = 2'd0;
        bus.rd_in = '0; bus.rd_val_in = '0; bus.issue_in = 1'b0;
        bus.issue_rd_in = '0; bus.rsa_in = '0; bus.rsb_in = '0;
        test_reset();
        test_half_writes();
        test_zero_reserved();
        test_bypass();
        test_scoreboard();
        test_chip_select();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
